// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction memory request/response bus between the fetch
// stage and instruction memory.
//   req_valid   fetch -> mem   request valid
//   req_ready   mem -> fetch   memory accepts the request
//   req_address fetch -> mem   word-aligned fetch address
//   rsp_valid   mem -> fetch   response valid, in request order, always accepted
//   rsp_data    mem -> fetch   returned instruction word
// Modports: master (fetch unit side), slave (memory side).
interface fetch_unit_if #(
  parameter int XLEN               = 64,
  parameter int INSTRUCTION_LENGTH = 32
);
  logic                          req_valid;
  logic                          req_ready;
  logic [XLEN-1:0]               req_address;
  logic                          rsp_valid;
  logic [INSTRUCTION_LENGTH-1:0] rsp_data;

  modport master (
    output req_valid, req_address,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_address,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding decode.
// Owns the fetch PC, issues sequential word requests to instruction memory,
// buffers returned words in a small prefetch FIFO, and drives the
// fetch-to-decode instruction register plus a one-ahead lookahead word.
// Redirects flush the FIFO and discard wrong-path responses still in flight.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   f_to_d_enable_ff         decode accepts a new instruction (0 = hold)
//   redirect_valid/_address  taken branch/jump target (low 2 bits ignored)
//   imem                     fetch_unit_if.master request/response bus
//   instruction/_pc/_valid   fetch-to-decode register
//   next_instruction/_valid  FIFO head lookahead (NOP when empty)
// Optional: define FETCH_PERF_COUNTERS_EN to add perf_bubble_count,
// perf_stall_count and perf_redirect_count (32-bit, saturating).
module fetch_unit #(
  parameter int              XLEN               = 64,
  parameter int              INSTRUCTION_LENGTH = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR       = '0,
  parameter int              FIFO_DEPTH         = 2,
  parameter int              MAX_OUTSTANDING    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          f_to_d_enable_ff,
  input  logic                          redirect_valid,
  input  logic [XLEN-1:0]               redirect_address,
  fetch_unit_if.master                  imem,
  output logic [INSTRUCTION_LENGTH-1:0] instruction,
  output logic [XLEN-1:0]               instruction_pc,
  output logic                          instruction_valid,
  output logic [INSTRUCTION_LENGTH-1:0] next_instruction,
  output logic                          next_instruction_valid
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]                   perf_bubble_count,
  output logic [31:0]                   perf_stall_count,
  output logic [31:0]                   perf_redirect_count
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int TAG_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int SUM_W = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;
  localparam logic [INSTRUCTION_LENGTH-1:0] NOP = INSTRUCTION_LENGTH'(32'h0000_0013);

  typedef enum logic {RUN, FLUSH} fetch_state_t;

  fetch_state_t state, state_next;

  logic [XLEN-1:0]               pc;
  logic [INSTRUCTION_LENGTH-1:0] fifo_data [FIFO_DEPTH];
  logic [XLEN-1:0]               fifo_pc   [FIFO_DEPTH];
  logic [PTR_W-1:0]              rd_ptr, wr_ptr;
  logic [CNT_W-1:0]              fifo_count;
  logic [XLEN-1:0]               tag_pc    [MAX_OUTSTANDING];
  logic [TAG_W-1:0]              tag_rd, tag_wr;
  logic [OUT_W-1:0]              outstanding, outstanding_next;
  logic [OUT_W-1:0]              drop, drop_next;

  logic req_fire, push, pop, load, fifo_empty;

  function automatic logic [TAG_W-1:0] tag_inc(input logic [TAG_W-1:0] p);
    return (p == TAG_W'(MAX_OUTSTANDING - 1)) ? '0 : p + TAG_W'(1);
  endfunction

  // A request is only issued when a FIFO slot is already reserved for its
  // response, so responses never need back-pressure.
  assign imem.req_valid   = rst && (state == RUN) &&
                            (SUM_W'(fifo_count) + SUM_W'(outstanding) < SUM_W'(FIFO_DEPTH)) &&
                            (outstanding < OUT_W'(MAX_OUTSTANDING));
  assign imem.req_address = pc;

  assign req_fire   = imem.req_valid && imem.req_ready;
  assign fifo_empty = (fifo_count == '0);
  assign load       = f_to_d_enable_ff || !instruction_valid;
  // Responses are discarded while drop is non-zero or when a redirect is
  // flushing the buffer in the same cycle.
  assign push       = imem.rsp_valid && (drop == '0) && !redirect_valid;
  // Pop uses the pre-edge FIFO state, so a word pushed into an empty FIFO
  // reaches decode one cycle later (no bypass).
  assign pop        = load && !fifo_empty && !redirect_valid;

  assign next_instruction_valid = !fifo_empty && !redirect_valid;
  assign next_instruction       = next_instruction_valid ? fifo_data[rd_ptr] : NOP;

  always_comb begin
    outstanding_next = outstanding;
    if (req_fire && !imem.rsp_valid)
      outstanding_next = outstanding + OUT_W'(1);
    else if (!req_fire && imem.rsp_valid)
      outstanding_next = outstanding - OUT_W'(1);
  end

  // Next-state logic. On a redirect every request still in flight after this
  // edge is wrong-path, so drop simply becomes the updated outstanding count;
  // this also covers a redirect arriving while already flushing.
  always_comb begin
    state_next = state;
    drop_next  = drop;
    if (redirect_valid) begin
      drop_next  = outstanding_next;
      state_next = (outstanding_next != '0) ? FLUSH : RUN;
    end else begin
      if (imem.rsp_valid && (drop != '0))
        drop_next = drop - OUT_W'(1);
      case (state)
        RUN:     state_next = RUN;
        FLUSH:   if (drop == '0) state_next = RUN;
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      drop  <= '0;
    end else begin
      state <= state_next;
      drop  <= drop_next;
    end
  end

  // Fetch PC and the in-order tag queue carrying each request's PC to its
  // response. The tag queue is not flushed on redirect: dropped responses
  // still retire their tag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_VECTOR;
      outstanding <= '0;
      tag_rd      <= '0;
      tag_wr      <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect_valid)
        pc <= redirect_address & ~XLEN'(3);
      else if (req_fire)
        pc <= pc + XLEN'(4);
      if (req_fire)
        tag_wr <= tag_inc(tag_wr);
      if (imem.rsp_valid)
        tag_rd <= tag_inc(tag_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire)
      tag_pc[tag_wr] <= pc;
    if (push) begin
      fifo_data[wr_ptr] <= imem.rsp_data;
      fifo_pc[wr_ptr]   <= tag_pc[tag_rd];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else if (redirect_valid) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Decode register: a redirect kills it even while decode is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instruction       <= NOP;
      instruction_pc    <= '0;
      instruction_valid <= 1'b0;
    end else if (redirect_valid) begin
      instruction       <= NOP;
      instruction_valid <= 1'b0;
    end else if (load) begin
      if (!fifo_empty) begin
        instruction       <= fifo_data[rd_ptr];
        instruction_pc    <= fifo_pc[rd_ptr];
        instruction_valid <= 1'b1;
      end else begin
        instruction       <= NOP;
        instruction_valid <= 1'b0;
      end
    end
  end

  rsp_into_full_fifo: assert property (@(posedge clk) disable iff (!rst)
    !(imem.rsp_valid && (drop == '0) && !redirect_valid && (fifo_count == CNT_W'(FIFO_DEPTH))));

`ifdef FETCH_PERF_COUNTERS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_bubble_count   <= '0;
      perf_stall_count    <= '0;
      perf_redirect_count <= '0;
    end else begin
      if ((redirect_valid || (load && fifo_empty)) && (perf_bubble_count != '1))
        perf_bubble_count <= perf_bubble_count + 32'd1;
      if (!f_to_d_enable_ff && instruction_valid && (perf_stall_count != '1))
        perf_stall_count <= perf_stall_count + 32'd1;
      if (redirect_valid && (perf_redirect_count != '1))
        perf_redirect_count <= perf_redirect_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
// tb_fetch_unit: randomized bench for fetch_unit with a queue-based reference
// model of the fetch pipeline and a variable-latency instruction memory.
module tb_fetch_unit;

  localparam int XLEN  = 64;
  localparam int ILEN  = 32;
  localparam int DEPTH = 2;
  localparam int MAXO  = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic            redirect;
  logic [XLEN-1:0] redirect_addr;
  logic [ILEN-1:0] instruction;
  logic [XLEN-1:0] instruction_pc;
  logic            instruction_valid;
  logic [ILEN-1:0] next_instruction;
  logic            next_instruction_valid;

  fetch_unit_if #(.XLEN(XLEN), .INSTRUCTION_LENGTH(ILEN)) imem ();

  fetch_unit #(
    .XLEN(XLEN), .INSTRUCTION_LENGTH(ILEN), .RESET_VECTOR('0),
    .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .f_to_d_enable_ff       (enable),
    .redirect_valid         (redirect),
    .redirect_address       (redirect_addr),
    .imem                   (imem),
    .instruction            (instruction),
    .instruction_pc         (instruction_pc),
    .instruction_valid      (instruction_valid),
    .next_instruction       (next_instruction),
    .next_instruction_valid (next_instruction_valid)
  );

  always #5 clk = ~clk;

  // Reference model: in-flight requests (with wrong-path flag), buffered words,
  // fetch PC, flushing flag and the decode register.
  typedef struct packed { logic [63:0] pc; logic stale; } req_t;
  typedef struct packed { logic [31:0] word; logic [63:0] pc; } entry_t;
  typedef struct packed { logic [63:0] addr; int due; } mem_t;

  req_t   inflight [$];
  entry_t fq       [$];
  mem_t   mem_q    [$];

  logic [63:0] m_fetch;
  bit          m_flushing;
  logic [31:0] m_instr;
  logic [63:0] m_ipc;
  bit          m_valid;
  int          cycle;
  int          total = 0;
  int          bad   = 0;

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_5A5A;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s cycle=%0d got=%h exp=%h", tag, cycle, got, exp);
    end
  endtask

  task automatic resetModel();
    inflight.delete();
    fq.delete();
    mem_q.delete();
    m_fetch    = '0;
    m_flushing = 0;
    m_instr    = NOP;
    m_ipc      = '0;
    m_valid    = 0;
  endtask

  // Asynchronous reset: values are checked before any clock edge occurs.
  task automatic doReset();
    rst = 1'b0;
    enable = 1'b0; redirect = 1'b0; redirect_addr = '0;
    imem.req_ready = 1'b0; imem.rsp_valid = 1'b0; imem.rsp_data = '0;
    #1;
    checkOutput("rst_req_valid",  imem.req_valid, 0);
    checkOutput("rst_instr_valid", instruction_valid, 0);
    checkOutput("rst_instruction", instruction, NOP);
    checkOutput("rst_instr_pc",    instruction_pc, 0);
    checkOutput("rst_next_valid",  next_instruction_valid, 0);
    @(negedge clk);
    resetModel();
    rst = 1'b1;
  endtask

  // One clock cycle: drive inputs at the falling edge, check, then advance
  // the model across the rising edge. Entered and left at a falling edge.
  task automatic applyStimulus(input bit en, input bit redir, input logic [63:0] raddr,
                               input bit ready, input int rsp_pct);
    bit          m_rv, fire, rsp, keep;
    logic [31:0] rdata;
    logic [63:0] rpc;
    int          stale_pre;
    req_t        r;
    entry_t      e;

    enable = en; redirect = redir; redirect_addr = raddr; imem.req_ready = ready;
    rsp = 0; rdata = '0; keep = 0; rpc = '0;
    if (mem_q.size() > 0 && mem_q[0].due <= cycle && $urandom_range(99) < rsp_pct) begin
      rsp   = 1;
      rdata = word_of(mem_q[0].addr);
      void'(mem_q.pop_front());
    end
    imem.rsp_valid = rsp;
    imem.rsp_data  = rdata;
    #1;

    m_rv = rst && !m_flushing && (fq.size() + inflight.size() < DEPTH) && (inflight.size() < MAXO);
    checkOutput("req_valid", imem.req_valid, m_rv);
    if (m_rv) checkOutput("req_address", imem.req_address, m_fetch);
    checkOutput("instr_valid", instruction_valid, m_valid);
    checkOutput("instruction", instruction, m_instr);
    if (m_valid) checkOutput("instr_pc", instruction_pc, m_ipc);
    if (!redir) begin
      checkOutput("next_valid", next_instruction_valid, fq.size() > 0);
      if (fq.size() > 0) checkOutput("next_instr", next_instruction, fq[0].word);
      else               checkOutput("next_instr", next_instruction, NOP);
    end

    if (imem.req_valid && ready) mem_q.push_back('{addr: imem.req_address, due: cycle + 1});
    fire = m_rv && ready;
    @(posedge clk);

    stale_pre = 0;
    foreach (inflight[i]) if (inflight[i].stale) stale_pre++;
    if (rsp) begin
      if (inflight.size() == 0) checkOutput("spurious_rsp", 1, 0);
      else begin
        r    = inflight.pop_front();
        keep = !r.stale;
        rpc  = r.pc;
      end
    end
    if (redir) begin
      fq.delete();
      m_instr = NOP;
      m_valid = 0;
    end else begin
      if (en || !m_valid) begin
        if (fq.size() > 0) begin
          e = fq.pop_front();
          m_instr = e.word; m_ipc = e.pc; m_valid = 1;
        end else begin
          m_instr = NOP; m_valid = 0;
        end
      end
      if (rsp && keep) fq.push_back('{word: word_of(rpc), pc: rpc});
    end
    if (fire) begin
      inflight.push_back('{pc: m_fetch, stale: 1'b0});
      m_fetch = m_fetch + 64'd4;
    end
    if (redir) begin
      foreach (inflight[i]) inflight[i].stale = 1'b1;
      m_fetch    = raddr & ~64'd3;
      m_flushing = (inflight.size() > 0);
    end else if (m_flushing && stale_pre == 0) begin
      m_flushing = 0;
    end
    cycle++;
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] raddr;
    cycle = 0;
    rst = 1'b0;
    @(negedge clk);
    doReset();

    // Streaming with immediate responses.
    repeat (10) applyStimulus(1, 0, '0, 1, 100);
    // Decode stall for three cycles.
    repeat (3)  applyStimulus(0, 0, '0, 1, 100);
    repeat (4)  applyStimulus(1, 0, '0, 1, 100);
    // Redirect to an unaligned target with requests in flight.
    repeat (2)  applyStimulus(1, 0, '0, 1, 0);
    applyStimulus(1, 1, 64'h1003, 1, 0);
    repeat (3)  applyStimulus(1, 0, '0, 1, 0);
    repeat (8)  applyStimulus(1, 0, '0, 1, 100);
    // Memory not ready for five cycles.
    repeat (5)  applyStimulus(1, 0, '0, 0, 100);
    repeat (4)  applyStimulus(1, 0, '0, 1, 100);
    // Second redirect while still flushing the first.
    repeat (2)  applyStimulus(1, 0, '0, 1, 0);
    applyStimulus(1, 1, 64'h1000, 1, 0);
    applyStimulus(1, 1, 64'h2000, 1, 0);
    repeat (2)  applyStimulus(1, 0, '0, 1, 0);
    repeat (8)  applyStimulus(1, 0, '0, 1, 100);
    // Address wrap at the top of the address space.
    applyStimulus(1, 1, 64'hFFFF_FFFF_FFFF_FFF8, 1, 100);
    repeat (8)  applyStimulus(1, 0, '0, 1, 100);

    // Reset in the middle of a busy stream.
    repeat (3)  applyStimulus(1, 0, '0, 1, 60);
    doReset();

    // Randomized traffic.
    for (int n = 0; n < 2500; n++) begin
      raddr = {$urandom(), $urandom()};
      if ($urandom_range(3) == 0) raddr = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
      applyStimulus($urandom_range(99) < 70, $urandom_range(99) < 4, raddr,
                    $urandom_range(99) < 75, 30 + 10 * (n / 400));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the pipeline control / decode stage.
- Owns the program counter and issues sequential requests to instruction memory over a valid/ready handshake.
- Buffers returned words in a small prefetch FIFO and drives the fetch-to-decode instruction register, plus a one-ahead lookahead word.
- Honours the decode stall enable and redirects from the jump/branch logic, discarding wrong-path responses still in flight.

Parameters:
XLEN, 64, address/PC width
INSTRUCTION_LENGTH, 32, instruction word width
RESET_VECTOR, 0, PC value loaded on reset
FIFO_DEPTH, 2, prefetch buffer entries (power of two, >=2)
MAX_OUTSTANDING, 2, max issued-but-unreturned imem requests

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset
f_to_d_enable_ff  in  1  1 = decode accepts a new instruction this cycle; 0 = hold
redirect_valid  in  1  branch/jump taken; redirect fetch
redirect_address  in  XLEN  target PC, low 2 bits ignored (forced 0)
imem_req_valid  out  1  request valid
imem_req_ready  in  1  memory accepts request
imem_req_address  out  XLEN  word-aligned fetch address
imem_rsp_valid  in  1  response valid, in request order, always accepted
imem_rsp_data  in  INSTRUCTION_LENGTH  returned word
instruction  out  INSTRUCTION_LENGTH  fetch-to-decode register
instruction_pc  out  XLEN  PC of instruction
instruction_valid  out  1  instruction is real (not bubble)
next_instruction  out  INSTRUCTION_LENGTH  FIFO head (lookahead), NOP when empty
next_instruction_valid  out  1  FIFO non-empty

Behaviour:
- Reset values (while rst=0):
  - fetch PC = RESET_VECTOR; FIFO empty; outstanding=0; drop=0.
  - instruction=32'h00000013 (NOP); instruction_pc=0; instruction_valid=0.
  - imem_req_valid=0; FSM=RUN.
- Request issue:
  - imem_req_valid=1 when FSM=RUN and (fifo_count + outstanding) < FIFO_DEPTH and outstanding < MAX_OUTSTANDING.
  - imem_req_address = fetch PC.
  - On valid&&ready: PC += 4, outstanding++.
  - Address wraps modulo 2^XLEN.
  - imem_req_valid may drop only in the cycle a redirect arrives.
- Response:
  - Each imem_rsp_valid decrements outstanding.
  - If drop>0: decrement drop and discard the word.
  - Otherwise push {word, PC} into the FIFO. The PC travels with each request through a parallel tag queue.
  - The reservation rule guarantees no overflow. A response arriving with the FIFO full is an assertion error.
- Decode register load:
  - When f_to_d_enable_ff=1 or instruction_valid=0:
    - If the FIFO is non-empty: pop the head into instruction/instruction_pc and set valid=1.
    - If the FIFO is empty: load NOP and set valid=0.
  - When f_to_d_enable_ff=0 and valid=1: hold all outputs.
  - A push and a pop in the same cycle on an empty FIFO does not bypass. The word appears one cycle later, giving 2-cycle latency from rsp to instruction.
- Redirect (highest priority, same edge):
  - PC = redirect_address & ~3.
  - FIFO flushed; instruction set to NOP with valid=0 (even if stalled).
  - drop = outstanding minus any response accepted this cycle.
  - A same-cycle accepted request also counts toward drop.
  - If drop>0 after the update, FSM=FLUSH, else RUN.
- FSM:
  - RUN: normal issue.
  - FLUSH: no issue; return to RUN the cycle after drop reaches 0.
  - A redirect in FLUSH re-captures the PC and adds any newly counted outstanding requests to drop.
- next_instruction:
  - Shows the FIFO head combinationally.
  - Shows NOP with valid=0 when the FIFO is empty or during the flush cycle.
- Reset mid-operation: all state cleared asynchronously. Responses arriving after reset deassertion for pre-reset requests are the memory's responsibility; the memory must be reset together with this block.

Optional Feature:
FETCH_PERF_COUNTERS_EN
- Defined:
  - Adds outputs perf_bubble_count, perf_stall_count and perf_redirect_count, each 32 bits, saturating, reset to 0.
  - Bubble count increments on cycles that load a NOP bubble.
  - Stall count increments on cycles with f_to_d_enable_ff=0 and valid=1.
  - Redirect count increments on each redirect_valid.
- Undefined: these ports and counters are absent; behaviour otherwise identical.

Test Plan:
- Reset release, ready=1, zero-latency responses with data=PC -> requests to 0x0,0x4,0x8; instruction_pc 0x0 shows valid 2 cycles after first rsp, then one per cycle.
- f_to_d_enable_ff=0 for 3 cycles mid-stream -> instruction held; imem_req_valid deasserts once fifo_count+outstanding=2; no words lost or duplicated.
- redirect_valid to 0x1003 with 2 outstanding -> next request 0x1000 only after 2 responses dropped; first valid instruction_pc=0x1000.
- imem_req_ready=0 for 5 cycles -> address stable; valid stays 1; instruction_valid falls to 0 once FIFO drains.
- Second redirect to 0x2000 during FLUSH -> final fetch starts at 0x2000; no 0x1000 instruction reaches decode.
- PC at 2^XLEN-4 -> next address 0x0 (wrap).
